// File: rtl/data_sram_responder_if.sv
// Purpose : SRAM-style access port between the CPU (master) and a memory responder (slave).
// Signals : en     - access request this cycle
//           wen    - byte write enables, bit i covers wdata[8i+7:8i]; all-zero means read
//           addr   - byte address, [1:0] ignored by the responder
//           wdata  - write data
//           rdata  - registered read data
//           rvalid - one-cycle pulse when rdata is updated by a completing read
interface data_sram_responder_if;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;

    modport master (
        output en, wen, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  en, wen, addr, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/data_sram_responder.sv
// Purpose : Memory-side responder for a CPU SRAM port. Holds a word-addressed
//           array, commits byte-lane writes on the accepting edge and returns
//           read data after a fixed READ_LATENCY. Keeps debug counters.
// Ports   : clk     - system clock, all state on posedge
//           resetn  - asynchronous active-low reset (array contents survive)
//           sram    - slave side of the SRAM access port
//           rd_cnt  - count of accepted reads (wraps)
//           wr_cnt  - count of accepted writes (wraps)
//           oor_err - sticky out-of-range access flag
module data_sram_responder #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [31:0] OOR_DATA     = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         resetn,
    data_sram_responder_if.slave         sram,
    output logic [31:0]                  rd_cnt,
    output logic [31:0]                  wr_cnt,
    output logic                         oor_err
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned PIPE_D = READ_LATENCY - 1;

    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_rdata;
    logic              r_rvalid;
    logic [31:0]       r_rd_cnt;
    logic [31:0]       r_wr_cnt;
    logic              r_oor_err;

    logic [ADDR_W-1:0] w_idx;
    logic              w_oor;
    logic              w_rd;
    logic              w_wr;
    logic [31:0]       w_rd_data;
    logic              w_tail_vld;
    logic [31:0]       w_tail_data;
    logic              w_unused_addr;

    // Access decode
    assign w_idx         = sram.addr[ADDR_W+1:2];
    assign w_oor         = |sram.addr[31:ADDR_W+2];
    assign w_rd          = sram.en && (sram.wen == 4'b0000);
    assign w_wr          = sram.en && (sram.wen != 4'b0000);
    assign w_rd_data     = w_oor ? OOR_DATA : r_mem[w_idx];
    assign w_unused_addr = ^sram.addr[1:0];

    // Array: not reset; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (w_wr && !w_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (sram.wen[i]) begin
                    r_mem[w_idx][8*i +: 8] <= sram.wdata[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline: READ_LATENCY-1 stages ahead of the output register, so the
    // data sampled at edge k reaches sram.rdata at edge k+READ_LATENCY-1.
    if (READ_LATENCY == 1) begin : g_direct
        assign w_tail_vld  = w_rd;
        assign w_tail_data = w_rd_data;
    end else begin : g_pipe
        logic [PIPE_D-1:0] r_vld;
        logic [31:0]       r_data [PIPE_D];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_vld <= '0;
                for (int i = 0; i < int'(PIPE_D); i++) begin
                    r_data[i] <= 32'h0;
                end
            end else begin
                r_vld[0]  <= w_rd;
                r_data[0] <= w_rd_data;
                for (int i = 1; i < int'(PIPE_D); i++) begin
                    r_vld[i]  <= r_vld[i-1];
                    r_data[i] <= r_data[i-1];
                end
            end
        end

        assign w_tail_vld  = r_vld[PIPE_D-1];
        assign w_tail_data = r_data[PIPE_D-1];
    end

    // Output register, counters and sticky error flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rdata   <= 32'h0;
            r_rvalid  <= 1'b0;
            r_rd_cnt  <= 32'h0;
            r_wr_cnt  <= 32'h0;
            r_oor_err <= 1'b0;
        end else begin
            r_rvalid <= w_tail_vld;
            if (w_tail_vld) begin
                r_rdata <= w_tail_data;
            end
            if (w_rd) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_wr) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            if (sram.en && w_oor) begin
                r_oor_err <= 1'b1;
            end
        end
    end

    assign sram.rdata  = r_rdata;
    assign sram.rvalid = r_rvalid;
    assign rd_cnt      = r_rd_cnt;
    assign wr_cnt      = r_wr_cnt;
    assign oor_err     = r_oor_err;

endmodule

// File: tb/tb_data_sram_responder.sv
// Purpose : Directed self-checking bench for data_sram_responder. Three instances
//           (READ_LATENCY 1, 3, 2) share clock and reset; inputs change and
//           outputs are sampled on the falling edge.
module tb_data_sram_responder;

    logic clk;
    logic resetn;

    logic        t_en    [3];
    logic [3:0]  t_wen   [3];
    logic [31:0] t_addr  [3];
    logic [31:0] t_wdata [3];

    logic [31:0] rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1, rd_cnt2, wr_cnt2;
    logic        oor0, oor1, oor2;

    int n_checks;
    int n_errors;

    data_sram_responder_if if0 ();
    data_sram_responder_if if1 ();
    data_sram_responder_if if2 ();

    assign if0.en = t_en[0];  assign if0.wen = t_wen[0];  assign if0.addr = t_addr[0];  assign if0.wdata = t_wdata[0];
    assign if1.en = t_en[1];  assign if1.wen = t_wen[1];  assign if1.addr = t_addr[1];  assign if1.wdata = t_wdata[1];
    assign if2.en = t_en[2];  assign if2.wen = t_wen[2];  assign if2.addr = t_addr[2];  assign if2.wdata = t_wdata[2];

    data_sram_responder #(.ADDR_W(10), .READ_LATENCY(1), .OOR_DATA(32'h0)) u_dut0 (
        .clk(clk), .resetn(resetn), .sram(if0.slave),
        .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0), .oor_err(oor0)
    );
    data_sram_responder #(.ADDR_W(10), .READ_LATENCY(3), .OOR_DATA(32'h0)) u_dut1 (
        .clk(clk), .resetn(resetn), .sram(if1.slave),
        .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1), .oor_err(oor1)
    );
    data_sram_responder #(.ADDR_W(10), .READ_LATENCY(2), .OOR_DATA(32'h0)) u_dut2 (
        .clk(clk), .resetn(resetn), .sram(if2.slave),
        .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2), .oor_err(oor2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input int s);
        case (s)
            0:       return if0.rdata;
            1:       return if1.rdata;
            default: return if2.rdata;
        endcase
    endfunction

    function automatic logic rvalid_of(input int s);
        case (s)
            0:       return if0.rvalid;
            1:       return if1.rvalid;
            default: return if2.rvalid;
        endcase
    endfunction

    // One access on instance s; called and returns on a falling edge
    task automatic access(input int s, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata);
        t_en[s]    = 1'b1;
        t_wen[s]   = wen;
        t_addr[s]  = addr;
        t_wdata[s] = wdata;
        @(negedge clk);
        t_en[s]    = 1'b0;
        t_wen[s]   = 4'h0;
    endtask

    initial begin
        int rv_count;
        n_checks = 0;
        n_errors = 0;
        resetn   = 1'b0;
        for (int s = 0; s < 3; s++) begin
            t_en[s] = 1'b0; t_wen[s] = 4'h0; t_addr[s] = 32'h0; t_wdata[s] = 32'h0;
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Reset state
        check("rst_rdata",  rdata_of(0), 32'h0);
        check("rst_rvalid", 32'(rvalid_of(0)), 32'h0);
        check("rst_rd_cnt", rd_cnt0, 32'h0);
        check("rst_wr_cnt", wr_cnt0, 32'h0);
        check("rst_oor",    32'(oor0), 32'h0);

        // Full write, partial write (lanes 0 and 2), read with latency 1
        access(0, 4'hF,    32'h10, 32'h1122_3344);
        check("wr_no_rvalid", 32'(rvalid_of(0)), 32'h0);
        access(0, 4'b0101, 32'h10, 32'hAABB_CCDD);
        access(0, 4'h0,    32'h10, 32'h0);
        check("partial_rdata",  rdata_of(0), 32'h11BB_33DD);
        check("partial_rvalid", 32'(rvalid_of(0)), 32'h1);
        @(negedge clk);
        check("rvalid_once", 32'(rvalid_of(0)), 32'h0);
        check("rdata_hold",  rdata_of(0), 32'h11BB_33DD);
        check("wr_cnt_2",    wr_cnt0, 32'd2);
        check("rd_cnt_1",    rd_cnt0, 32'd1);

        // Back-to-back reads, latency 3
        for (int i = 0; i < 4; i++) access(1, 4'hF, 32'(4 * i), 32'hA0 + 32'(i));
        check("l3_rdata_idle", rdata_of(1), 32'h0);
        rv_count = 0;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                t_en[1] = 1'b1; t_wen[1] = 4'h0; t_addr[1] = 32'(4 * c);
            end else begin
                t_en[1] = 1'b0;
            end
            @(negedge clk);
            if (rvalid_of(1)) rv_count++;
            if (c >= 2 && c <= 5) begin
                check("l3_rvalid", 32'(rvalid_of(1)), 32'h1);
                check("l3_rdata",  rdata_of(1), 32'hA0 + 32'(c - 2));
            end else begin
                check("l3_rvalid_idle", 32'(rvalid_of(1)), 32'h0);
            end
        end
        t_en[1] = 1'b0;
        check("l3_rvalid_count", 32'(rv_count), 32'd4);
        check("l3_rdata_hold",   rdata_of(1), 32'hA3);
        check("l3_rd_cnt",       rd_cnt1, 32'd4);

        // Write then immediate read
        access(0, 4'hF, 32'h20, 32'hCAFE_F00D);
        access(0, 4'h0, 32'h20, 32'h0);
        check("wr_rd_fwd", rdata_of(0), 32'hCAFE_F00D);

        // Out-of-range write must not alias onto word 0
        access(0, 4'hF, 32'h0, 32'h5A5A_5A5A);
        check("oor_clear", 32'(oor0), 32'h0);
        access(0, 4'hF, 32'h1234_0000, 32'hDEAD_BEEF);
        check("oor_set", 32'(oor0), 32'h1);
        access(0, 4'h0, 32'h0, 32'h0);
        check("oor_word0", rdata_of(0), 32'h5A5A_5A5A);
        access(0, 4'h0, 32'h1234_0000, 32'h0);
        check("oor_rdata",  rdata_of(0), 32'h0);
        check("oor_rvalid", 32'(rvalid_of(0)), 32'h1);
        check("oor_sticky", 32'(oor0), 32'h1);
        check("oor_wr_cnt", wr_cnt0, 32'd5);
        check("oor_rd_cnt", rd_cnt0, 32'd4);

        // Reset during an in-flight read, latency 2
        access(2, 4'hF, 32'h40, 32'h0BAD_CAFE);
        t_en[2] = 1'b1; t_wen[2] = 4'h0; t_addr[2] = 32'h40;
        @(negedge clk);
        t_en[2] = 1'b0;
        check("l2_not_yet", 32'(rvalid_of(2)), 32'h0);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("flush_rvalid", 32'(rvalid_of(2)), 32'h0);
            check("flush_rdata",  rdata_of(2), 32'h0);
        end
        check("flush_oor", 32'(oor0), 32'h0);
        access(2, 4'h0, 32'h40, 32'h0);
        check("l2_lat_rvalid0", 32'(rvalid_of(2)), 32'h0);
        @(negedge clk);
        check("l2_survive_rvalid", 32'(rvalid_of(2)), 32'h1);
        check("l2_survive_rdata",  rdata_of(2), 32'h0BAD_CAFE);
        check("l2_rd_cnt",         rd_cnt2, 32'd1);
        access(0, 4'h0, 32'h20, 32'h0);
        check("survive_dut0", rdata_of(0), 32'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
